id_stage_fwd: RTL and testbench
===============================

Name: id_stage_fwd

Overview:
- Parametrised instruction-decode / operand-fetch pipeline register for the 16-bit five-stage CPU.
- Latches the decoded instruction plus operands A, B and store-data into the EX stage.
- Resolves RAW hazards by forwarding from EX, MEM and WB, in a fixed and consistent priority.
- Adds behaviour the CPU lacks today: load-use stall detection with bubble insertion, an explicit flush, an optional hard-wired zero register, and a saturating stall counter.

Parameters:
- DATA_W, 16: datapath width. Must be ≥ 8.
- ZERO_REG_EN, 0: when 1, r0 reads as 0 and is never a forwarding target.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- en  in  1  stage advance; equivalent to the CPU being in the exec state
- flush  in  1  squash the instruction in ID (taken branch or jump)
- id_ir  in  16  instruction in ID
- mem_ir  in  16  instruction in MEM
- wb_ir  in  16  instruction in WB
- alu_out  in  DATA_W  EX-stage ALU result
- mem_result  in  DATA_W  MEM-stage ALU result (reg_C)
- wb_result  in  DATA_W  WB-stage result (reg_C1); carries ALU or load data
- d_datain  in  DATA_W  data-memory read data for the MEM-stage LOAD
- gr_flat  in  8*DATA_W  register file; r(k) = gr_flat[k*DATA_W +: DATA_W]
- ex_ir  out  16  instruction to EX
- reg_a  out  DATA_W  operand A
- reg_b  out  DATA_W  operand B
- smdr  out  DATA_W  store data
- stall_req  out  1  combinational; holds IF and ID this cycle
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Instruction fields: op = ir[15:11], r1 = ir[10:8], r2 = ir[6:4], r3 = ir[2:0], imm8 = ir[7:0], imm4 = ir[3:0]. Opcode encodings come from the shared definitions header.
- ALU writer class (destination r1): LDIH, ADD, ADDI, ADDC, SUB, SUBI, SUBC, AND, OR, XOR, SLL, SRL, SLA, SRA. LOAD also writes r1.
- Operand A source:
  - r1 for BZ, BNZ, BN, BNN, BC, BNC, JMPR, ADDI, SUBI, LDIH.
  - r2 for LOAD, STORE, ADD, ADDC, SUB, SUBC, CMP, AND, OR, XOR, SLL, SRL, SLA, SRA.
  - Otherwise reg_a holds its value.
- Operand B source:
  - Zero-extended imm4 for LOAD, STORE, SLL, SRL, SLA, SRA.
  - LDIH: imm8 << (DATA_W-8).
  - Zero-extended imm8 for branches, JMPR, ADDI, SUBI.
  - Register r3 for ADD, ADDC, SUB, SUBC, CMP, AND, OR, XOR.
  - Otherwise reg_b holds its value.
- Store data: smdr ← register r1 for STORE only; otherwise smdr holds.
- Register-read resolution, per source register s, first match wins:
  1. ex_ir is an ALU writer with r1 == s → alu_out
  2. mem_ir is an ALU writer with r1 == s → mem_result
  3. mem_ir is LOAD with r1 == s → d_datain
  4. wb_ir is an ALU writer or LOAD with r1 == s → wb_result
  5. otherwise → gr_flat r(s)
- Zero register (ZERO_REG_EN=1): s == 0 always yields 0, with no forwarding.
- Load-use hazard: stall_req = en & ~flush & (ex_ir op == LOAD) & (ex_ir r1 is read by id_ir as A-source, B-register or smdr-source). With ZERO_REG_EN=1, an ex_ir r1 of 0 never stalls.
- Register update priority, one action per cycle:
  - reset low: ex_ir, reg_a, reg_b, smdr ← 0; stall_cnt ← 0. Asynchronous.
  - en=0: all registers hold, stall_req=0.
  - flush=1: ex_ir ← 0 (NOP); reg_a, reg_b, smdr hold. Flush wins over a simultaneous stall.
  - stall_req=1: ex_ir ← 0 (bubble); operands hold; stall_cnt += 1, saturating at all-ones. The next cycle re-decodes the same id_ir, and the load value is then forwarded from d_datain.
  - normal: ex_ir ← id_ir, except op JUMP → 0; operands per the rules above.
- Latency: one clock from id_ir to ex_ir and operands. stall_req is same-cycle combinational.
- Reset asserted mid-stall clears the counter and outputs immediately; no stall state is retained.

Test Plan:
- Reset: drive reset=0 with random inputs → all outputs 0, stall_req=0. After release with en=0 for 3 cycles → outputs unchanged.
- EX forwarding: ex_ir=ADD r3; id_ir=ADD r5,r3,r3; alu_out=0x1234; gr r3=0x0001 → reg_a=reg_b=0x1234.
- Priority: ex_ir=ADD r2 (alu_out=0x00AA), mem_ir=ADD r2 (mem_result=0x00BB), id_ir=ADDI r2,0x05 → reg_a=0x00AA, reg_b=0x0005. Remove the EX match → reg_a=0x00BB.
- Load-use: ex_ir=LOAD r4; id_ir=STORE r4,(r1)+2 → stall_req=1, ex_ir=0, stall_cnt=1. Next cycle mem_ir=LOAD r4, d_datain=0xBEEF → smdr=0xBEEF, ex_ir=STORE.
- Flush vs stall: same load-use setup with flush=1 → stall_req=0, ex_ir=0, stall_cnt unchanged. id_ir=JUMP → ex_ir=0.
- Zero register (ZERO_REG_EN=1, DATA_W=32): ex_ir=ADD r0 (alu_out=0x55); id_ir=LDIH r0,0x12 → reg_a=0, reg_b=0x12000000. Saturation: CNT_W=2, 5 stalls → stall_cnt=3.

Source files
------------

// File: rtl/id_stage_fwd_if.sv
// Bundles the ID/EX register's pipeline context and outputs. The master
// side is the rest of the datapath. The slave side is the decode stage.
interface id_stage_fwd_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
);
  logic                en;
  logic                flush;
  logic [15:0]         id_ir;
  logic [15:0]         mem_ir;
  logic [15:0]         wb_ir;
  logic [DATA_W-1:0]   alu_out;
  logic [DATA_W-1:0]   mem_result;
  logic [DATA_W-1:0]   wb_result;
  logic [DATA_W-1:0]   d_datain;
  logic [8*DATA_W-1:0] gr_flat;
  logic [15:0]         ex_ir;
  logic [DATA_W-1:0]   reg_a;
  logic [DATA_W-1:0]   reg_b;
  logic [DATA_W-1:0]   smdr;
  logic                stall_req;
  logic [CNT_W-1:0]    stall_cnt;

  modport master (
    output en, flush, id_ir, mem_ir, wb_ir, alu_out, mem_result, wb_result,
           d_datain, gr_flat,
    input  ex_ir, reg_a, reg_b, smdr, stall_req, stall_cnt
  );

  modport slave (
    input  en, flush, id_ir, mem_ir, wb_ir, alu_out, mem_result, wb_result,
           d_datain, gr_flat,
    output ex_ir, reg_a, reg_b, smdr, stall_req, stall_cnt
  );
endinterface

// File: rtl/id_stage_fwd.sv
// ID/EX pipeline register for the 16-bit five-stage CPU.
// It decodes the ID instruction and reads operands through an EX/MEM/WB
// bypass network. It detects load-use hazards and inserts bubbles for them.
// It handles flush, an optional hard-wired r0, and a saturating stall counter.
module id_stage_fwd #(
  parameter int DATA_W      = 16,
  parameter int ZERO_REG_EN = 0,
  parameter int CNT_W       = 16
) (
  input  logic          clock,
  input  logic          reset,
  id_stage_fwd_if.slave stage
);
  // Opcode encodings shared with the rest of the CPU.
  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_HALT  = 5'b00001;
  localparam logic [4:0] OP_LOAD  = 5'b00010;
  localparam logic [4:0] OP_STORE = 5'b00011;
  localparam logic [4:0] OP_SLL   = 5'b00100;
  localparam logic [4:0] OP_SLA   = 5'b00101;
  localparam logic [4:0] OP_SRL   = 5'b00110;
  localparam logic [4:0] OP_SRA   = 5'b00111;
  localparam logic [4:0] OP_ADD   = 5'b01000;
  localparam logic [4:0] OP_ADDI  = 5'b01001;
  localparam logic [4:0] OP_SUB   = 5'b01010;
  localparam logic [4:0] OP_SUBI  = 5'b01011;
  localparam logic [4:0] OP_CMP   = 5'b01100;
  localparam logic [4:0] OP_AND   = 5'b01101;
  localparam logic [4:0] OP_OR    = 5'b01110;
  localparam logic [4:0] OP_XOR   = 5'b01111;
  localparam logic [4:0] OP_LDIH  = 5'b10000;
  localparam logic [4:0] OP_ADDC  = 5'b10001;
  localparam logic [4:0] OP_SUBC  = 5'b10010;
  localparam logic [4:0] OP_JUMP  = 5'b11000;
  localparam logic [4:0] OP_JMPR  = 5'b11001;
  localparam logic [4:0] OP_BZ    = 5'b11010;
  localparam logic [4:0] OP_BNZ   = 5'b11011;
  localparam logic [4:0] OP_BN    = 5'b11100;
  localparam logic [4:0] OP_BNN   = 5'b11101;
  localparam logic [4:0] OP_BC    = 5'b11110;
  localparam logic [4:0] OP_BNC   = 5'b11111;

  // Instructions whose ALU result lands in r1.
  function automatic logic is_alu_writer(input logic [4:0] op);
    logic hit;
    case (op)
      OP_LDIH, OP_ADD, OP_ADDI, OP_ADDC, OP_SUB, OP_SUBI, OP_SUBC,
      OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SLA, OP_SRA: hit = 1'b1;
      default:                                               hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Pipeline state.
  logic [15:0]       ex_ir_reg, ex_ir_next;
  logic [DATA_W-1:0] reg_a_reg, reg_a_next;
  logic [DATA_W-1:0] reg_b_reg, reg_b_next;
  logic [DATA_W-1:0] smdr_reg, smdr_next;
  logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;

  // Instruction fields.
  logic [4:0] id_op, ex_op, mem_op, wb_op;
  logic [2:0] id_r1, id_r2, id_r3, ex_r1, mem_r1, wb_r1;
  logic [7:0] id_imm8;
  logic [3:0] id_imm4;

  assign id_op   = stage.id_ir[15:11];
  assign id_r1   = stage.id_ir[10:8];
  assign id_r2   = stage.id_ir[6:4];
  assign id_r3   = stage.id_ir[2:0];
  assign id_imm8 = stage.id_ir[7:0];
  assign id_imm4 = stage.id_ir[3:0];
  assign ex_op   = ex_ir_reg[15:11];
  assign ex_r1   = ex_ir_reg[10:8];
  assign mem_op  = stage.mem_ir[15:11];
  assign mem_r1  = stage.mem_ir[10:8];
  assign wb_op   = stage.wb_ir[15:11];
  assign wb_r1   = stage.wb_ir[10:8];

  // Producers visible to the bypass network.
  logic ex_alu, mem_alu, mem_load, wb_writes, ex_load;
  assign ex_alu    = is_alu_writer(ex_op);
  assign ex_load   = (ex_op == OP_LOAD);
  assign mem_alu   = is_alu_writer(mem_op);
  assign mem_load  = (mem_op == OP_LOAD);
  assign wb_writes = is_alu_writer(wb_op) || (wb_op == OP_LOAD);

  // Operand source classification of the ID instruction.
  logic a_from_r1, a_from_r2, b_from_r3, b_imm4, b_imm8, b_ldih, st_from_r1;

  // Decide where operands A, B and the store data come from for this opcode.
  always_comb begin
    a_from_r1  = 1'b0;
    a_from_r2  = 1'b0;
    b_from_r3  = 1'b0;
    b_imm4     = 1'b0;
    b_imm8     = 1'b0;
    b_ldih     = 1'b0;
    st_from_r1 = 1'b0;
    case (id_op)
      OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC, OP_JMPR, OP_ADDI, OP_SUBI: begin
        a_from_r1 = 1'b1;
        b_imm8    = 1'b1;
      end
      OP_LDIH: begin
        a_from_r1 = 1'b1;
        b_ldih    = 1'b1;
      end
      OP_LOAD, OP_SLL, OP_SRL, OP_SLA, OP_SRA: begin
        a_from_r2 = 1'b1;
        b_imm4    = 1'b1;
      end
      OP_STORE: begin
        a_from_r2  = 1'b1;
        b_imm4     = 1'b1;
        st_from_r1 = 1'b1;
      end
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP, OP_AND, OP_OR, OP_XOR: begin
        a_from_r2 = 1'b1;
        b_from_r3 = 1'b1;
      end
      default: ;
    endcase
  end

  // Three register read ports: 0 = operand A, 1 = operand B, 2 = store data.
  logic [2:0][2:0]        src_reg;
  logic [2:0]             src_used;
  logic [2:0][DATA_W-1:0] src_val;
  logic [2:0]             load_hit;

  assign src_reg[0]  = a_from_r1 ? id_r1 : id_r2;
  assign src_reg[1]  = id_r3;
  assign src_reg[2]  = id_r1;
  assign src_used[0] = a_from_r1 | a_from_r2;
  assign src_used[1] = b_from_r3;
  assign src_used[2] = st_from_r1;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_port
      logic [2:0]        sreg;
      logic              is_zero;
      logic [DATA_W-1:0] val;

      assign sreg    = src_reg[gi];
      assign is_zero = (ZERO_REG_EN != 0) && (sreg == 3'd0);

      // Bypass: the youngest in-flight producer wins, then fall back to the register file.
      always_comb begin
        val = stage.gr_flat[int'(sreg) * DATA_W +: DATA_W];
        if (is_zero)                          val = '0;
        else if (ex_alu && ex_r1 == sreg)     val = stage.alu_out;
        else if (mem_alu && mem_r1 == sreg)   val = stage.mem_result;
        else if (mem_load && mem_r1 == sreg)  val = stage.d_datain;
        else if (wb_writes && wb_r1 == sreg)  val = stage.wb_result;
      end

      assign src_val[gi]  = val;
      // A load in EX cannot be forwarded yet. A hardwired r0 never needs it.
      assign load_hit[gi] = src_used[gi] && (sreg == ex_r1) && !is_zero;
    end
  endgenerate

  logic stall;
  assign stall = stage.en && !stage.flush && ex_load && (|load_hit);

  logic [DATA_W-1:0] ldih_val;
  assign ldih_val = DATA_W'(id_imm8) << (DATA_W - 8);

  // Next-state selection: hold, flush, stall bubble, or normal advance.
  always_comb begin
    ex_ir_next     = ex_ir_reg;
    reg_a_next     = reg_a_reg;
    reg_b_next     = reg_b_reg;
    smdr_next      = smdr_reg;
    stall_cnt_next = stall_cnt_reg;
    if (stage.en) begin
      if (stage.flush) begin
        ex_ir_next = '0;
      end else if (stall) begin
        ex_ir_next = '0;
        if (stall_cnt_reg != {CNT_W{1'b1}}) stall_cnt_next = stall_cnt_reg + CNT_W'(1);
      end else begin
        ex_ir_next = (id_op == OP_JUMP) ? 16'h0000 : stage.id_ir;
        if (src_used[0]) reg_a_next = src_val[0];
        if (b_from_r3)   reg_b_next = src_val[1];
        else if (b_imm4) reg_b_next = DATA_W'(id_imm4);
        else if (b_imm8) reg_b_next = DATA_W'(id_imm8);
        else if (b_ldih) reg_b_next = ldih_val;
        if (st_from_r1)  smdr_next  = src_val[2];
      end
    end
  end

  // Pipeline register with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_ir_reg     <= '0;
      reg_a_reg     <= '0;
      reg_b_reg     <= '0;
      smdr_reg      <= '0;
      stall_cnt_reg <= '0;
    end else begin
      ex_ir_reg     <= ex_ir_next;
      reg_a_reg     <= reg_a_next;
      reg_b_reg     <= reg_b_next;
      smdr_reg      <= smdr_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign stage.ex_ir     = ex_ir_reg;
  assign stage.reg_a     = reg_a_reg;
  assign stage.reg_b     = reg_b_reg;
  assign stage.smdr      = smdr_reg;
  assign stage.stall_req = stall;
  assign stage.stall_cnt = stall_cnt_reg;

  // Low instruction fields of the later stages carry nothing this stage needs.
  logic unused_bits;
  assign unused_bits = ^{ex_ir_reg[7:0], stage.mem_ir[7:0], stage.wb_ir[7:0]};
endmodule

// File: tb/tb_id_stage_fwd.sv
// Testbench for id_stage_fwd. Two instances share one stimulus stream:
// dut0 has DATA_W=16, no zero register and CNT_W=16.
// dut1 has DATA_W=32, a hardwired r0 and CNT_W=2.
// A reference model pushes the expected outputs for every cycle into a
// queue. A monitor pops an entry and compares it shortly after each falling edge.
module tb_id_stage_fwd;
  localparam logic [4:0] OP_NOP = 5'b00000, OP_HALT = 5'b00001, OP_LOAD = 5'b00010,
                         OP_STORE = 5'b00011, OP_SLL = 5'b00100, OP_SLA = 5'b00101,
                         OP_SRL = 5'b00110, OP_SRA = 5'b00111, OP_ADD = 5'b01000,
                         OP_ADDI = 5'b01001, OP_SUB = 5'b01010, OP_SUBI = 5'b01011,
                         OP_CMP = 5'b01100, OP_AND = 5'b01101, OP_OR = 5'b01110,
                         OP_XOR = 5'b01111, OP_LDIH = 5'b10000, OP_ADDC = 5'b10001,
                         OP_SUBC = 5'b10010, OP_JUMP = 5'b11000, OP_JMPR = 5'b11001,
                         OP_BZ = 5'b11010, OP_BNZ = 5'b11011, OP_BN = 5'b11100,
                         OP_BNN = 5'b11101, OP_BC = 5'b11110, OP_BNC = 5'b11111;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  id_stage_fwd_if #(.DATA_W(16), .CNT_W(16)) bus0 ();
  id_stage_fwd_if #(.DATA_W(32), .CNT_W(2))  bus1 ();

  id_stage_fwd #(.DATA_W(16), .ZERO_REG_EN(0), .CNT_W(16)) dut0 (
    .clock(clock), .reset(reset), .stage(bus0));
  id_stage_fwd #(.DATA_W(32), .ZERO_REG_EN(1), .CNT_W(2)) dut1 (
    .clock(clock), .reset(reset), .stage(bus1));

  typedef struct packed {
    logic        stall;
    logic [15:0] ex_ir;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] st;
    logic [31:0] cnt;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   tests = 0;
  int   fails = 0;

  // Stimulus for the current cycle.
  logic        in_en, in_flush;
  logic [15:0] in_id, in_mem, in_wb;
  logic [31:0] in_alu, in_memr, in_wbr, in_din;
  logic [31:0] in_gr [8];

  // Reference state, one entry per DUT.
  logic [15:0] m_ex  [2];
  logic [31:0] m_a   [2];
  logic [31:0] m_b   [2];
  logic [31:0] m_st  [2];
  int unsigned m_cnt [2];

  logic [4:0] op_tbl [27];

  function automatic int dw(input int k);             return (k == 0) ? 16 : 32; endfunction
  function automatic logic zen(input int k);          return (k == 1); endfunction
  function automatic int unsigned cmax(input int k);  return (k == 0) ? 65535 : 3; endfunction
  function automatic logic [31:0] dmask(input int k); return (k == 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF; endfunction

  function automatic logic alu_wr(input logic [15:0] ir);
    return ir[15:11] inside {OP_LDIH, OP_ADD, OP_ADDI, OP_ADDC, OP_SUB, OP_SUBI, OP_SUBC,
                             OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SLA, OP_SRA};
  endfunction
  function automatic logic a_r1(input logic [4:0] op);
    return op inside {OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC, OP_JMPR, OP_ADDI, OP_SUBI, OP_LDIH};
  endfunction
  function automatic logic a_r2(input logic [4:0] op);
    return op inside {OP_LOAD, OP_STORE, OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP,
                      OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SLA, OP_SRA};
  endfunction
  function automatic logic b_r3(input logic [4:0] op);
    return op inside {OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP, OP_AND, OP_OR, OP_XOR};
  endfunction
  function automatic logic b_i4(input logic [4:0] op);
    return op inside {OP_LOAD, OP_STORE, OP_SLL, OP_SRL, OP_SLA, OP_SRA};
  endfunction
  function automatic logic b_i8(input logic [4:0] op);
    return op inside {OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC, OP_JMPR, OP_ADDI, OP_SUBI};
  endfunction

  // Set of registers the instruction reads, as an 8-bit membership mask.
  function automatic logic [7:0] reads(input logic [15:0] ir);
    logic [7:0] m;
    m = '0;
    if (a_r1(ir[15:11]))       m[ir[10:8]] = 1'b1;
    if (a_r2(ir[15:11]))       m[ir[6:4]]  = 1'b1;
    if (b_r3(ir[15:11]))       m[ir[2:0]]  = 1'b1;
    if (ir[15:11] == OP_STORE) m[ir[10:8]] = 1'b1;
    return m;
  endfunction

  // Architectural value of register s as seen by the instruction in ID.
  function automatic logic [31:0] rd(input int k, input logic [2:0] s);
    logic [31:0] v;
    if (zen(k) && s == 3'd0)                                     v = 32'd0;
    else if (alu_wr(m_ex[k]) && m_ex[k][10:8] == s)              v = in_alu;
    else if (alu_wr(in_mem) && in_mem[10:8] == s)                v = in_memr;
    else if (in_mem[15:11] == OP_LOAD && in_mem[10:8] == s)      v = in_din;
    else if ((alu_wr(in_wb) || in_wb[15:11] == OP_LOAD) && in_wb[10:8] == s) v = in_wbr;
    else                                                         v = in_gr[s];
    return v & dmask(k);
  endfunction

  // Push what DUT k should show this cycle, then advance its model across the clock edge.
  task automatic model_cycle(input int k);
    exp_t        e;
    logic        stall;
    logic [7:0]  rmask;
    logic [2:0]  er1;
    logic [4:0]  op;
    logic [31:0] na, nb, ns;
    if (!reset) begin
      m_ex[k] = '0; m_a[k] = '0; m_b[k] = '0; m_st[k] = '0; m_cnt[k] = 0;
    end
    er1   = m_ex[k][10:8];
    rmask = reads(in_id);
    stall = reset && in_en && !in_flush && (m_ex[k][15:11] == OP_LOAD) && rmask[er1] &&
            !(zen(k) && er1 == 3'd0);
    e.stall = stall; e.ex_ir = m_ex[k]; e.a = m_a[k]; e.b = m_b[k]; e.st = m_st[k];
    e.cnt = m_cnt[k];
    if (k == 0) q0.push_back(e); else q1.push_back(e);
    if (reset && in_en) begin
      if (in_flush) begin
        m_ex[k] = '0;
      end else if (stall) begin
        m_ex[k] = '0;
        if (m_cnt[k] < cmax(k)) m_cnt[k] = m_cnt[k] + 1;
      end else begin
        op = in_id[15:11];
        na = m_a[k]; nb = m_b[k]; ns = m_st[k];
        if (a_r1(op))      na = rd(k, in_id[10:8]);
        else if (a_r2(op)) na = rd(k, in_id[6:4]);
        if (b_i4(op))            nb = {28'd0, in_id[3:0]};
        else if (op == OP_LDIH)  nb = ({24'd0, in_id[7:0]} << (dw(k) - 8)) & dmask(k);
        else if (b_i8(op))       nb = {24'd0, in_id[7:0]};
        else if (b_r3(op))       nb = rd(k, in_id[2:0]);
        if (op == OP_STORE)      ns = rd(k, in_id[10:8]);
        m_a[k] = na; m_b[k] = nb; m_st[k] = ns;
        m_ex[k] = (op == OP_JUMP) ? 16'h0000 : in_id;
      end
    end
  endtask

  task automatic drive();
    bus0.en = in_en;           bus1.en = in_en;
    bus0.flush = in_flush;     bus1.flush = in_flush;
    bus0.id_ir = in_id;        bus1.id_ir = in_id;
    bus0.mem_ir = in_mem;      bus1.mem_ir = in_mem;
    bus0.wb_ir = in_wb;        bus1.wb_ir = in_wb;
    bus0.alu_out = in_alu[15:0];     bus1.alu_out = in_alu;
    bus0.mem_result = in_memr[15:0]; bus1.mem_result = in_memr;
    bus0.wb_result = in_wbr[15:0];   bus1.wb_result = in_wbr;
    bus0.d_datain = in_din[15:0];    bus1.d_datain = in_din;
    for (int i = 0; i < 8; i++) begin
      bus0.gr_flat[i*16 +: 16] = in_gr[i][15:0];
      bus1.gr_flat[i*32 +: 32] = in_gr[i];
    end
  endtask

  // Apply the current stimulus for one clock period, starting at a falling edge.
  task automatic step();
    drive();
    model_cycle(0);
    model_cycle(1);
    @(negedge clock);
  endtask

  task automatic rand_data();
    in_alu = $urandom; in_memr = $urandom; in_wbr = $urandom; in_din = $urandom;
    for (int i = 0; i < 8; i++) in_gr[i] = $urandom;
  endtask

  task automatic quiet();
    in_en = 1'b1; in_flush = 1'b0; in_mem = 16'h0000; in_wb = 16'h0000;
    rand_data();
  endtask

  function automatic logic [2:0] rreg();
    return ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 4));
  endfunction

  function automatic logic [15:0] rand_ir();
    logic [15:0] ir;
    ir = 16'($urandom);
    ir[15:11] = ($urandom_range(0, 4) == 0) ? OP_LOAD : op_tbl[$urandom_range(0, 26)];
    ir[10:8] = rreg(); ir[6:4] = rreg(); ir[2:0] = rreg();
    return ir;
  endfunction

  function automatic logic [15:0] rr(input logic [4:0] op, input logic [2:0] r1,
                                     input logic [2:0] r2, input logic [2:0] r3);
    return {op, r1, 1'b0, r2, 1'b0, r3};
  endfunction
  function automatic logic [15:0] ri(input logic [4:0] op, input logic [2:0] r1,
                                     input logic [7:0] imm);
    return {op, r1, imm};
  endfunction

  task automatic check(input int k, input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL dut%0d %s: got %h expected %h (t=%0t)", k, nm, got, exp, $time);
    end
  endtask

  // Monitor: outputs are valid every cycle, sampled 3 time units after the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #3;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check(0, "stall_req", {31'd0, bus0.stall_req}, {31'd0, e.stall});
        check(0, "ex_ir", {16'd0, bus0.ex_ir}, {16'd0, e.ex_ir});
        check(0, "reg_a", {16'd0, bus0.reg_a}, e.a);
        check(0, "reg_b", {16'd0, bus0.reg_b}, e.b);
        check(0, "smdr", {16'd0, bus0.smdr}, e.st);
        check(0, "stall_cnt", {16'd0, bus0.stall_cnt}, e.cnt);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check(1, "stall_req", {31'd0, bus1.stall_req}, {31'd0, e.stall});
        check(1, "ex_ir", {16'd0, bus1.ex_ir}, {16'd0, e.ex_ir});
        check(1, "reg_a", bus1.reg_a, e.a);
        check(1, "reg_b", bus1.reg_b, e.b);
        check(1, "smdr", bus1.smdr, e.st);
        check(1, "stall_cnt", {30'd0, bus1.stall_cnt}, e.cnt);
        $display("[TB] t=%0t ex_ir=%h/%h a=%h/%h b=%h/%h stall=%b/%b cnt=%0d/%0d", $time,
                 bus0.ex_ir, bus1.ex_ir, bus0.reg_a, bus1.reg_a, bus0.reg_b, bus1.reg_b,
                 bus0.stall_req, bus1.stall_req, bus0.stall_cnt, bus1.stall_cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    op_tbl = '{OP_NOP, OP_HALT, OP_LOAD, OP_STORE, OP_SLL, OP_SLA, OP_SRL, OP_SRA, OP_ADD,
               OP_ADDI, OP_SUB, OP_SUBI, OP_CMP, OP_AND, OP_OR, OP_XOR, OP_LDIH, OP_ADDC,
               OP_SUBC, OP_JUMP, OP_JMPR, OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC};
    for (int k = 0; k < 2; k++) begin
      m_ex[k] = '0; m_a[k] = '0; m_b[k] = '0; m_st[k] = '0; m_cnt[k] = 0;
    end
    reset = 1'b0;
    quiet();
    in_id = rand_ir();
    drive();
    @(negedge clock);

    // Reset held low with random inputs, then released with the stage idle.
    for (int i = 0; i < 3; i++) begin
      reset = 1'b0; rand_data(); in_en = 1'b1; in_flush = 1'b0;
      in_id = rand_ir(); in_mem = rand_ir(); in_wb = rand_ir();
      step();
    end
    for (int i = 0; i < 3; i++) begin
      reset = 1'b1; rand_data(); in_en = 1'b0; in_flush = 1'($urandom);
      in_id = rand_ir(); in_mem = rand_ir(); in_wb = rand_ir();
      step();
    end

    // EX forwarding to both operands.
    quiet(); in_id = rr(OP_ADD, 3'd3, 3'd0, 3'd0); step();
    quiet(); in_id = rr(OP_ADD, 3'd5, 3'd3, 3'd3); in_alu = 32'h1234; in_gr[3] = 32'h1; step();

    // EX beats MEM, then MEM alone.
    quiet(); in_id = rr(OP_ADD, 3'd2, 3'd1, 3'd1); step();
    quiet(); in_id = ri(OP_ADDI, 3'd2, 8'h05); in_alu = 32'h00AA;
    in_mem = rr(OP_ADD, 3'd2, 3'd0, 3'd0); in_memr = 32'h00BB; step();
    quiet(); in_id = 16'h0000; step();
    quiet(); in_id = ri(OP_ADDI, 3'd2, 8'h05); in_mem = rr(OP_ADD, 3'd2, 3'd0, 3'd0);
    in_memr = 32'h00BB; step();

    // Load-use stall, then the load value arrives from d_datain.
    quiet(); in_id = rr(OP_LOAD, 3'd4, 3'd1, 3'd0); step();
    quiet(); in_id = rr(OP_STORE, 3'd4, 3'd1, 3'd2); step();
    quiet(); in_id = rr(OP_STORE, 3'd4, 3'd1, 3'd2); in_mem = rr(OP_LOAD, 3'd4, 3'd1, 3'd0);
    in_din = 32'hBEEF; step();

    // Flush wins over a stall. A JUMP enters EX as a NOP.
    quiet(); in_id = rr(OP_LOAD, 3'd4, 3'd1, 3'd0); step();
    quiet(); in_id = rr(OP_STORE, 3'd4, 3'd1, 3'd2); in_flush = 1'b1; step();
    quiet(); in_id = ri(OP_JUMP, 3'd0, 8'h40); step();

    // Zero register and LDIH shift.
    quiet(); in_id = rr(OP_ADD, 3'd0, 3'd1, 3'd2); step();
    quiet(); in_id = ri(OP_LDIH, 3'd0, 8'h12); in_alu = 32'h55; step();

    // Five load-use stalls to saturate the 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      quiet(); in_id = rr(OP_LOAD, 3'd6, 3'd1, 3'd0); step();
      quiet(); in_id = rr(OP_ADD, 3'd1, 3'd6, 3'd2); step();
      quiet(); in_id = rr(OP_ADD, 3'd1, 3'd6, 3'd2); in_mem = rr(OP_LOAD, 3'd6, 3'd1, 3'd0); step();
    end

    // Reset asserted in the middle of a stall.
    quiet(); in_id = rr(OP_LOAD, 3'd4, 3'd1, 3'd0); step();
    quiet(); in_id = rr(OP_STORE, 3'd4, 3'd1, 3'd2); reset = 1'b0; step();
    reset = 1'b1; quiet(); in_id = rr(OP_STORE, 3'd4, 3'd1, 3'd2); step();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      rand_data();
      reset    = ($urandom_range(0, 99) != 0);
      in_en    = ($urandom_range(0, 9) != 0);
      in_flush = ($urandom_range(0, 9) == 0);
      in_id    = rand_ir();
      in_mem   = rand_ir();
      in_wb    = rand_ir();
      step();
    end

    quiet(); in_id = 16'h0000; step();
    #5;
    tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
